pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 Parameter STEP, default 16'd4, sequential increment.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 redir_valid  input  1  redirect request (branch taken / jump) from execute.
REQ-006 redir_target  input  16  redirect destination address.
REQ-007 redir_ready  output  1  redirect accepted this cycle when high with redir_valid.
REQ-008 halt  input  1  level request to stop issuing fetches.
REQ-009 fetch_valid  output  1  fetch_pc is a valid request.
REQ-010 fetch_pc  output  16  current fetch address.
REQ-011 fetch_ready  input  1  instruction memory accepts fetch_pc this cycle.
REQ-012 flush  output  1  one-cycle pulse: the redirect was applied to the PC, so younger fetches are discarded.
REQ-013 fault  output  1  sticky misaligned-redirect flag.

Function
REQ-014 States SHALL be: BOOT, RUN, HALTED, FAULT.
REQ-015 Fetch handshake: transfer occurs iff fetch_valid && fetch_ready.
  - fetch_pc SHALL hold stable while fetch_valid && !fetch_ready.
REQ-016 BOOT:
  - fetch_valid=0, redir_ready=0.
  - Next cycle go to RUN with pc=RESET_PC.
REQ-017 RUN, no redirect, transfer: pc <= pc + STEP, modulo 2^16 (16'hFFFC + 4 -> 16'h0000, no flag).
REQ-018 RUN, no redirect, no transfer: pc unchanged.
REQ-019 RUN, redir_valid && redir_ready, fetch_valid=0 or transfer this cycle: pc <= redir_target; flush=1 next cycle. The redirect wins over pc+STEP.
REQ-020 RUN, redir_valid && redir_ready, fetch_valid && !fetch_ready: target captured into a one-entry pending buffer; pc unchanged.
REQ-021 redir_ready SHALL be 1 only in RUN with the pending buffer empty; 0 in all other cases.
REQ-022 Pending buffer full, on the next transfer: pc <= pending target, buffer cleared, flush=1 next cycle.
REQ-023 Redirects are accepted only with redir_ready=1; a redir_valid while redir_ready=0 is neither captured nor applied.
REQ-024 Accepted redir_target with [1:0] != 2'b00:
  - go to FAULT; pc not updated; no flush.
  - The same rule applies when the target enters via the pending buffer.
REQ-025 FAULT: fault=1, fetch_valid=0, redir_ready=0; exit only by reset.
REQ-026 halt=1 in RUN:
  - If fetch_valid && !fetch_ready, stay in RUN until the transfer completes, then enter HALTED.
  - Otherwise enter HALTED next cycle.
  - A pending redirect is applied on entry to HALTED.
REQ-027 HALTED: fetch_valid=0, redir_ready=0, pc held; return to RUN the cycle after halt=0.
REQ-028 flush SHALL be registered, exactly one cycle per applied redirect, never in BOOT, HALTED or FAULT.
REQ-029 fetch_valid=1 only in RUN.

Reset
REQ-030 rst_n=0 at a clock edge, from any state and mid-handshake, SHALL force:
  - state=BOOT, pc=RESET_PC, pending buffer empty.
  - fetch_valid=0, redir_ready=0, flush=0, fault=0.
REQ-031 First fetch_valid=1 SHALL appear exactly 2 cycles after the first edge with rst_n=1, with fetch_pc=RESET_PC.
REQ-032 Redirect requests present during reset or BOOT SHALL be ignored.

Verification
REQ-033 Reset release, fetch_ready=1 constant -> fetch_pc sequence 0x0000, 0x0004, 0x0008 on consecutive cycles, flush=0 throughout.
REQ-034 pc=0x0010, fetch_ready=1, redir_valid=1 with target 0x0100 -> next fetch_pc=0x0100, flush=1 for one cycle, 0x0014 never issued.
REQ-035 pc=0x0020, fetch_ready=0, redirect to 0x0200 accepted:
  - fetch_pc holds at 0x0020 and redir_ready=0 while the buffer is full.
  - After fetch_ready=1: fetch_pc=0x0200 and flush pulses.
REQ-036 Wrap-around and fault:
  - pc=0xFFFC, transfer -> fetch_pc=0x0000.
  - Redirect to 0x0102 -> fault=1, fetch_valid=0, stays set until rst_n=0.
REQ-037 Halt during a stalled fetch at 0x0040 with a pending redirect to 0x0080:
  - Enter HALTED only after the transfer; pc=0x0080.
  - After halt=0: fetch resumes at 0x0080.
REQ-038 Reset mid-operation: rst_n=0 for one cycle while the buffer is full in RUN -> buffer cleared; the first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: boots to RESET_PC, steps by STEP on each accepted
// fetch, applies execute redirects (directly or via a one-entry pending buffer), halts and faults.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] STEP     = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir_valid,
    input  logic [15:0] redir_target,
    output logic        redir_ready,
    input  logic        halt,
    output logic        fetch_valid,
    output logic [15:0] fetch_pc,
    input  logic        fetch_ready,
    output logic        flush,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [15:0] pend_tgt_q, pend_tgt_d;
    logic        boot_wait_q, boot_wait_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        redir_ready_q, redir_ready_d;
    logic        flush_q, flush_d;
    logic        fault_q, fault_d;

    logic        xfer_s;
    logic        redir_acc_s;
    logic        apply_s;
    logic [15:0] apply_tgt_s;

    function automatic logic misaligned(input logic [15:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    assign xfer_s      = fetch_valid_q && fetch_ready;
    assign redir_acc_s = redir_valid && redir_ready_q;

    // Next-state computation for the sequencer FSM and its registered outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        boot_wait_d = boot_wait_q;
        flush_d     = 1'b0;
        apply_s     = 1'b0;
        apply_tgt_s = pend_tgt_q;

        case (state_q)
            ST_BOOT: begin
                // BOOT is held for one full cycle after reset release before fetching.
                if (boot_wait_q) begin
                    boot_wait_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (pend_q) begin
                    if (xfer_s) begin
                        apply_s     = 1'b1;
                        apply_tgt_s = pend_tgt_q;
                        pend_d      = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                    end
                end else if (redir_acc_s) begin
                    if (!fetch_valid_q || xfer_s) begin
                        apply_s     = 1'b1;
                        apply_tgt_s = redir_target;
                    end else begin
                        pend_d     = 1'b1;
                        pend_tgt_d = redir_target;
                    end
                end else if (xfer_s) begin
                    pc_d = pc_q + STEP;
                end else begin
                    pc_d = pc_q;
                end

                if (halt && (!fetch_valid_q || xfer_s)) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end

                // A redirect applied on the way into HALTED moves the PC but raises no flush.
                if (apply_s) begin
                    if (misaligned(apply_tgt_s)) begin
                        state_d = ST_FAULT;
                        pc_d    = pc_q;
                    end else begin
                        pc_d    = apply_tgt_s;
                        flush_d = (state_d == ST_RUN);
                    end
                end else begin
                    flush_d = 1'b0;
                end
            end
            ST_HALTED: begin
                if (!halt) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        fetch_valid_d = (state_d == ST_RUN);
        redir_ready_d = (state_d == ST_RUN) && !pend_d;
        fault_d       = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            pend_q        <= 1'b0;
            pend_tgt_q    <= 16'h0000;
            boot_wait_q   <= 1'b1;
            fetch_valid_q <= 1'b0;
            redir_ready_q <= 1'b0;
            flush_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_tgt_q    <= pend_tgt_d;
            boot_wait_q   <= boot_wait_d;
            fetch_valid_q <= fetch_valid_d;
            redir_ready_q <= redir_ready_d;
            flush_q       <= flush_d;
            fault_q       <= fault_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = pc_q;
    assign redir_ready = redir_ready_q;
    assign flush       = flush_q;
    assign fault       = fault_q;

endmodule
